regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- Destination of the writeback bus: holds the 32x32 GPR file plus HI/LO, and resolves ID-stage operand reads.
- Read path resolves across in-flight EX/MEM results and the same-cycle WB write; raises a load-use stall request.
- Sits inside ID. Consumes the WB register-write bus and the EX/MEM forwarding buses; feeds operand data to the decode/issue logic.

Parameters:
- REG_NUM, 32, number of GPRs; address width is fixed at 5.
- DATA_W, 32, GPR/HI/LO width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wb_to_rf_bus  in  38  {we, waddr[4:0], wdata[31:0]}; GPR write from WB
- mem_to_id_bus  in  38  {we, waddr, wdata}; MEM-stage result
- ex_to_id_bus  in  38  {we, waddr, wdata}; EX-stage result
- ex_is_load  in  1  EX instruction is a load (wdata not yet valid)
- wb_hilo_bus  in  66  {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}; HI/LO commit from WB
- mem_hilo_bus  in  66  same format, MEM stage
- ex_hilo_bus  in  66  same format, EX stage
- rs_ren  in  1  port-1 read used
- rs_addr  in  5  port-1 address
- rt_ren  in  1  port-2 read used
- rt_addr  in  5  port-2 address
- rs_rdata  out  32  resolved port-1 operand
- rt_rdata  out  32  resolved port-2 operand
- hi_rdata  out  32  resolved HI
- lo_rdata  out  32  resolved LO
- stallreq_load  out  1  load-use stall request to the stall controller

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is synchronous, active-high.
  - On rst: all 32 GPRs, HI and LO are cleared to 0 at the clock edge.
  - While rst=1: all rdata outputs are 0 and stallreq_load is 0.
- Array write:
  - At posedge, if wb.we=1 and wb.waddr!=0, then gpr[waddr] <= wdata.
  - Writes to r0 are discarded; r0 always reads 0.
  - HI is written when wb hi_we=1; LO is written when wb lo_we=1. The two enables are independent.
- Operand resolution: combinational, zero latency, per port (rs and rt identical).
  - addr==0 or ren=0 -> 0.
  - else ex.we && ex.waddr==addr -> ex.wdata.
  - else mem.we && mem.waddr==addr -> mem.wdata.
  - else wb.we && wb.waddr==addr -> wb.wdata (same-cycle write-through).
  - else gpr[addr].
  - Strict priority is EX > MEM > WB > array (youngest wins).
  - A bus with waddr==0 never forwards, even when we=1.
- HI/LO resolution: same youngest-wins order, applied independently per half.
  - Example: EX writes only LO while MEM writes HI -> hi_rdata=mem.hi, lo_rdata=ex.lo.
- Load-use stall:
  - stallreq_load = ex_is_load & ex.we & (ex.waddr!=0) & ((rs_ren & rs_addr==ex.waddr) | (rt_ren & rt_addr==ex.waddr)).
  - While the stall is asserted, the operand value selected for the matching port is don't-care.
  - Loads in MEM do not stall; their data is valid on mem_to_id_bus.
- Latency: a value committed by WB in cycle N is served from the array from cycle N+1, and via the WB bypass in cycle N.
- Simultaneous events:
  - All three buses may target the same register; the priority above decides.
  - A WB write and a read of the same address in the same cycle returns the new data.
  - Reset asserted mid-stream clears the array; any WB write presented in that cycle is dropped.
- No stall input: the array always accepts WB writes. WB itself bubbles its bus when stalled.

Decomposition:
- Shared definitions in lib/defines.vh:
  - bus widths WB_TO_RF_WD=38, EX_TO_ID_WD/MEM_TO_ID_WD=38, HILO_BUS_WD=66;
  - field offsets for we/waddr/wdata;
  - Stop/NoStop.
- One natural sub-module: fwd_mux_5a. It is the per-port priority selector (address, three buses, array data -> operand) and is instantiated twice.
- HI/LO selection is small and stays inline.

Test Plan:
- rst=1 for 2 cycles, then read r1..r31 -> all 0; stallreq_load=0.
- WB writes r5=0x1234_5678 in cycle N; rs_addr=5 in cycle N -> 0x12345678 via bypass; in cycle N+1 with WB idle -> 0x12345678 from array.
- r8 set up as follows:
  - array holds r8=1;
  - WB writes r8=2; MEM writes r8=3; EX writes r8=4 with ex_is_load=0;
  - rs_addr=rt_addr=8 -> both read 4;
  - drop EX -> 3; drop MEM -> 2.
- WB/EX write r0=0xFFFF_FFFF -> rs_addr=0 reads 0 and the array stays 0.
- ex_is_load=1, ex writes r9; rt_ren=1, rt_addr=9 -> stallreq_load=1. With rt_ren=0 -> 0. Same load in MEM with data 0xAB -> stall 0, rt_rdata=0xAB.
- HI/LO cases:
  - WB commits hi=0x11, lo=0x22; EX has lo_we=1, lo=0x33 -> hi_rdata=0x11, lo_rdata=0x33.
  - Next cycle, all buses idle -> 0x11/0x22.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass_pkg: shared bus widths, bus field layouts and the forwarding
// hit test used by the ID-stage register file and its bypass selectors.
//   rf_wr_t   : {we, waddr[4:0], wdata[31:0]}              (38 bits)
//   hilo_wr_t : {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]} (66 bits)
package regfile_bypass_pkg;

    localparam int unsigned GPR_W        = 32;
    localparam int unsigned RF_ADDR_W    = 5;

    localparam int unsigned WB_TO_RF_WD  = 38;
    localparam int unsigned EX_TO_ID_WD  = 38;
    localparam int unsigned MEM_TO_ID_WD = 38;
    localparam int unsigned HILO_BUS_WD  = 66;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] waddr;
        logic [GPR_W-1:0]     wdata;
    } rf_wr_t;

    typedef struct packed {
        logic             hi_we;
        logic             lo_we;
        logic [GPR_W-1:0] hi_wdata;
        logic [GPR_W-1:0] lo_wdata;
    } hilo_wr_t;

    // A bus targeting r0 never forwards, even with we=1.
    function automatic logic fwd_hit(input logic                 we,
                                     input logic [RF_ADDR_W-1:0] waddr,
                                     input logic [RF_ADDR_W-1:0] addr);
        return we && (waddr != '0) && (waddr == addr);
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if: bundles the writeback/forwarding buses, the two ID read
// ports and the resolved operand outputs of the register file.
//   master : pipeline side (drives buses and read requests, takes operands)
//   slave  : register file side
import regfile_bypass_pkg::*;

interface regfile_bypass_if;

    logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    ex_is_load;
    logic [HILO_BUS_WD-1:0]  wb_hilo_bus;
    logic [HILO_BUS_WD-1:0]  mem_hilo_bus;
    logic [HILO_BUS_WD-1:0]  ex_hilo_bus;
    logic                    rs_ren;
    logic [RF_ADDR_W-1:0]    rs_addr;
    logic                    rt_ren;
    logic [RF_ADDR_W-1:0]    rt_addr;
    logic [GPR_W-1:0]        rs_rdata;
    logic [GPR_W-1:0]        rt_rdata;
    logic [GPR_W-1:0]        hi_rdata;
    logic [GPR_W-1:0]        lo_rdata;
    logic                    stallreq_load;

    modport master (
        output wb_to_rf_bus, mem_to_id_bus, ex_to_id_bus, ex_is_load,
               wb_hilo_bus, mem_hilo_bus, ex_hilo_bus,
               rs_ren, rs_addr, rt_ren, rt_addr,
        input  rs_rdata, rt_rdata, hi_rdata, lo_rdata, stallreq_load
    );

    modport slave (
        input  wb_to_rf_bus, mem_to_id_bus, ex_to_id_bus, ex_is_load,
               wb_hilo_bus, mem_hilo_bus, ex_hilo_bus,
               rs_ren, rs_addr, rt_ren, rt_addr,
        output rs_rdata, rt_rdata, hi_rdata, lo_rdata, stallreq_load
    );

endinterface

// File: rtl/regfile_bypass_fwd_mux_5a.sv
// fwd_mux_5a: per-port operand selector. Picks the youngest in-flight write
// to the requested register (EX > MEM > WB) and falls back to array data.
//   ren, addr      : read request
//   ex, mem, wb    : forwarding buses
//   rf_rdata       : array contents at addr
//   rdata          : resolved operand (0 for r0 or unused port)
module fwd_mux_5a
    import regfile_bypass_pkg::*;
(
    input  logic                 ren,
    input  logic [RF_ADDR_W-1:0] addr,
    input  rf_wr_t               ex,
    input  rf_wr_t               mem,
    input  rf_wr_t               wb,
    input  logic [GPR_W-1:0]     rf_rdata,
    output logic [GPR_W-1:0]     rdata
);

    always_comb begin
        rdata = rf_rdata;
        if (!ren || addr == '0) begin
            rdata = '0;
        end else if (fwd_hit(ex.we, ex.waddr, addr)) begin
            rdata = ex.wdata;
        end else if (fwd_hit(mem.we, mem.waddr, addr)) begin
            rdata = mem.wdata;
        end else if (fwd_hit(wb.we, wb.waddr, addr)) begin
            rdata = wb.wdata;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32x32 GPR file plus HI/LO, written by WB, with ID-stage
// operand resolution across EX/MEM/WB results and a load-use stall request.
//   clk, rst : clock, synchronous active-high reset
//   rf       : slave side of regfile_bypass_if (buses, read ports, operands)
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    regfile_bypass_if.slave  rf
);

    rf_wr_t   wb, mem, ex;
    hilo_wr_t wb_hl, mem_hl, ex_hl;

    assign wb     = rf_wr_t'(rf.wb_to_rf_bus);
    assign mem    = rf_wr_t'(rf.mem_to_id_bus);
    assign ex     = rf_wr_t'(rf.ex_to_id_bus);
    assign wb_hl  = hilo_wr_t'(rf.wb_hilo_bus);
    assign mem_hl = hilo_wr_t'(rf.mem_hilo_bus);
    assign ex_hl  = hilo_wr_t'(rf.ex_hilo_bus);

    logic [DATA_W-1:0] gpr_q [REG_NUM];
    logic [DATA_W-1:0] gpr_d [REG_NUM];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Array update; reset wins over a WB write presented in the same cycle.
    always_comb begin
        gpr_d = gpr_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                gpr_d[i] = '0;
            end
            hi_d = '0;
            lo_d = '0;
        end else begin
            if (wb.we && wb.waddr != '0) begin
                gpr_d[wb.waddr] = wb.wdata;
            end
            if (wb_hl.hi_we) begin
                hi_d = wb_hl.hi_wdata;
            end
            if (wb_hl.lo_we) begin
                lo_d = wb_hl.lo_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        gpr_q <= gpr_d;
        hi_q  <= hi_d;
        lo_q  <= lo_d;
    end

    logic [GPR_W-1:0] rs_fwd, rt_fwd;

    fwd_mux_5a u_rs_mux (
        .ren      (rf.rs_ren),
        .addr     (rf.rs_addr),
        .ex       (ex),
        .mem      (mem),
        .wb       (wb),
        .rf_rdata (gpr_q[rf.rs_addr]),
        .rdata    (rs_fwd)
    );

    fwd_mux_5a u_rt_mux (
        .ren      (rf.rt_ren),
        .addr     (rf.rt_addr),
        .ex       (ex),
        .mem      (mem),
        .wb       (wb),
        .rf_rdata (gpr_q[rf.rt_addr]),
        .rdata    (rt_fwd)
    );

    // HI and LO resolve independently: each half takes the youngest stage
    // that writes that half.
    logic [GPR_W-1:0] hi_fwd, lo_fwd;

    always_comb begin
        if (ex_hl.hi_we) begin
            hi_fwd = ex_hl.hi_wdata;
        end else if (mem_hl.hi_we) begin
            hi_fwd = mem_hl.hi_wdata;
        end else if (wb_hl.hi_we) begin
            hi_fwd = wb_hl.hi_wdata;
        end else begin
            hi_fwd = hi_q;
        end

        if (ex_hl.lo_we) begin
            lo_fwd = ex_hl.lo_wdata;
        end else if (mem_hl.lo_we) begin
            lo_fwd = mem_hl.lo_wdata;
        end else if (wb_hl.lo_we) begin
            lo_fwd = wb_hl.lo_wdata;
        end else begin
            lo_fwd = lo_q;
        end
    end

    // An EX load's wdata is not yet valid, so a consumer of it must stall.
    logic load_hit;

    always_comb begin
        load_hit = rf.ex_is_load &&
                   ((rf.rs_ren && fwd_hit(ex.we, ex.waddr, rf.rs_addr)) ||
                    (rf.rt_ren && fwd_hit(ex.we, ex.waddr, rf.rt_addr)));
    end

    always_comb begin
        rf.rs_rdata      = rst ? '0 : rs_fwd;
        rf.rt_rdata      = rst ? '0 : rt_fwd;
        rf.hi_rdata      = rst ? '0 : hi_fwd;
        rf.lo_rdata      = rst ? '0 : lo_fwd;
        rf.stallreq_load = (!rst && load_hit) ? Stop : NoStop;
    end

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_bypass_if bus_if ();

    regfile_bypass #(
        .REG_NUM (32),
        .DATA_W  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] mk_wr(input logic we, input logic [4:0] addr,
                                          input logic [31:0] data);
        return {we, addr, data};
    endfunction

    function automatic logic [65:0] mk_hl(input logic hi_we, input logic lo_we,
                                          input logic [31:0] hi, input logic [31:0] lo);
        return {hi_we, lo_we, hi, lo};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_if.wb_to_rf_bus  = '0;
        bus_if.mem_to_id_bus = '0;
        bus_if.ex_to_id_bus  = '0;
        bus_if.ex_is_load    = 1'b0;
        bus_if.wb_hilo_bus   = '0;
        bus_if.mem_hilo_bus  = '0;
        bus_if.ex_hilo_bus   = '0;
    endtask

    initial begin
        idle_all();
        bus_if.rs_ren  = 1'b0;
        bus_if.rs_addr = '0;
        bus_if.rt_ren  = 1'b0;
        bus_if.rt_addr = '0;
        rst = 1'b1;
        #1;

        // Outputs forced to zero during reset even with live forwarding.
        bus_if.ex_to_id_bus = mk_wr(1'b1, 5'd3, 32'hDEAD_BEEF);
        bus_if.ex_is_load   = 1'b1;
        bus_if.ex_hilo_bus  = mk_hl(1'b1, 1'b1, 32'h1, 32'h2);
        bus_if.rs_ren = 1'b1; bus_if.rs_addr = 5'd3;
        bus_if.rt_ren = 1'b1; bus_if.rt_addr = 5'd3;
        #1;
        check_eq("rst_rs", bus_if.rs_rdata, 32'h0);
        check_eq("rst_rt", bus_if.rt_rdata, 32'h0);
        check_eq("rst_hi", bus_if.hi_rdata, 32'h0);
        check_eq("rst_lo", bus_if.lo_rdata, 32'h0);
        check_eq("rst_stall", {31'b0, bus_if.stallreq_load}, 32'h0);
        idle_all();
        step();
        step();
        rst = 1'b0;
        bus_if.rt_ren = 1'b0;

        // Array cleared by reset.
        for (int i = 1; i < 32; i++) begin
            bus_if.rs_addr = 5'(i);
            #1;
            check_eq($sformatf("reset_r%0d", i), bus_if.rs_rdata, 32'h0);
        end
        check_eq("reset_stall", {31'b0, bus_if.stallreq_load}, 32'h0);
        check_eq("reset_hi", bus_if.hi_rdata, 32'h0);
        check_eq("reset_lo", bus_if.lo_rdata, 32'h0);

        // WB bypass in cycle N, array in cycle N+1.
        bus_if.wb_to_rf_bus = mk_wr(1'b1, 5'd5, 32'h1234_5678);
        bus_if.rs_addr = 5'd5;
        #1;
        check_eq("r5_wb_bypass", bus_if.rs_rdata, 32'h1234_5678);
        step();
        bus_if.wb_to_rf_bus = '0;
        bus_if.rt_ren = 1'b1; bus_if.rt_addr = 5'd5;
        #1;
        check_eq("r5_array_rs", bus_if.rs_rdata, 32'h1234_5678);
        check_eq("r5_array_rt", bus_if.rt_rdata, 32'h1234_5678);

        // Unused port reads 0.
        bus_if.rs_ren = 1'b0;
        #1;
        check_eq("r5_ren0", bus_if.rs_rdata, 32'h0);
        bus_if.rs_ren = 1'b1;

        // r8 priority ladder.
        bus_if.wb_to_rf_bus = mk_wr(1'b1, 5'd8, 32'h1);
        step();
        bus_if.wb_to_rf_bus  = mk_wr(1'b1, 5'd8, 32'h2);
        bus_if.mem_to_id_bus = mk_wr(1'b1, 5'd8, 32'h3);
        bus_if.ex_to_id_bus  = mk_wr(1'b1, 5'd8, 32'h4);
        bus_if.rs_addr = 5'd8; bus_if.rt_addr = 5'd8;
        #1;
        check_eq("r8_ex_rs", bus_if.rs_rdata, 32'h4);
        check_eq("r8_ex_rt", bus_if.rt_rdata, 32'h4);
        check_eq("r8_nostall", {31'b0, bus_if.stallreq_load}, 32'h0);
        bus_if.ex_to_id_bus = '0;
        #1;
        check_eq("r8_mem", bus_if.rs_rdata, 32'h3);
        bus_if.mem_to_id_bus = '0;
        #1;
        check_eq("r8_wb", bus_if.rt_rdata, 32'h2);
        bus_if.wb_to_rf_bus = '0;
        #1;
        check_eq("r8_array", bus_if.rs_rdata, 32'h1);

        // Writes to r0 neither forward nor stick.
        bus_if.wb_to_rf_bus  = mk_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus_if.mem_to_id_bus = mk_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus_if.ex_to_id_bus  = mk_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus_if.rs_addr = 5'd0;
        #1;
        check_eq("r0_fwd", bus_if.rs_rdata, 32'h0);
        step();
        idle_all();
        #1;
        check_eq("r0_array", bus_if.rs_rdata, 32'h0);

        // Load-use stall.
        bus_if.rs_addr = 5'd1;
        bus_if.ex_is_load   = 1'b1;
        bus_if.ex_to_id_bus = mk_wr(1'b1, 5'd9, 32'h55);
        bus_if.rt_ren = 1'b1; bus_if.rt_addr = 5'd9;
        #1;
        check_eq("load_rt_stall", {31'b0, bus_if.stallreq_load}, 32'h1);
        bus_if.rt_ren = 1'b0;
        #1;
        check_eq("load_rt_ren0", {31'b0, bus_if.stallreq_load}, 32'h0);
        bus_if.rs_addr = 5'd9;
        #1;
        check_eq("load_rs_stall", {31'b0, bus_if.stallreq_load}, 32'h1);
        bus_if.ex_to_id_bus = mk_wr(1'b0, 5'd9, 32'h55);
        #1;
        check_eq("load_we0", {31'b0, bus_if.stallreq_load}, 32'h0);
        bus_if.ex_to_id_bus = mk_wr(1'b1, 5'd0, 32'h55);
        bus_if.rs_addr = 5'd0;
        #1;
        check_eq("load_r0", {31'b0, bus_if.stallreq_load}, 32'h0);
        bus_if.ex_is_load    = 1'b0;
        bus_if.ex_to_id_bus  = '0;
        bus_if.mem_to_id_bus = mk_wr(1'b1, 5'd9, 32'hAB);
        bus_if.rt_ren = 1'b1; bus_if.rt_addr = 5'd9;
        #1;
        check_eq("mem_load_stall", {31'b0, bus_if.stallreq_load}, 32'h0);
        check_eq("mem_load_data", bus_if.rt_rdata, 32'hAB);
        idle_all();

        // HI/LO.
        bus_if.wb_hilo_bus = mk_hl(1'b1, 1'b1, 32'h11, 32'h22);
        bus_if.ex_hilo_bus = mk_hl(1'b0, 1'b1, 32'h0, 32'h33);
        #1;
        check_eq("hilo_wb_hi", bus_if.hi_rdata, 32'h11);
        check_eq("hilo_ex_lo", bus_if.lo_rdata, 32'h33);
        step();
        idle_all();
        #1;
        check_eq("hilo_arr_hi", bus_if.hi_rdata, 32'h11);
        check_eq("hilo_arr_lo", bus_if.lo_rdata, 32'h22);
        bus_if.mem_hilo_bus = mk_hl(1'b1, 1'b0, 32'h44, 32'h0);
        bus_if.ex_hilo_bus  = mk_hl(1'b0, 1'b1, 32'h0, 32'h55);
        #1;
        check_eq("hilo_mem_hi", bus_if.hi_rdata, 32'h44);
        check_eq("hilo_ex_lo2", bus_if.lo_rdata, 32'h55);
        idle_all();
        bus_if.wb_hilo_bus = mk_hl(1'b1, 1'b0, 32'h66, 32'h99);
        step();
        idle_all();
        #1;
        check_eq("hi_only_hi", bus_if.hi_rdata, 32'h66);
        check_eq("hi_only_lo", bus_if.lo_rdata, 32'h22);

        // Reset mid-stream drops the concurrent WB write and clears state.
        rst = 1'b1;
        bus_if.wb_to_rf_bus = mk_wr(1'b1, 5'd7, 32'h777);
        step();
        rst = 1'b0;
        idle_all();
        bus_if.rs_addr = 5'd7; bus_if.rt_addr = 5'd5;
        #1;
        check_eq("midrst_r7", bus_if.rs_rdata, 32'h0);
        check_eq("midrst_r5", bus_if.rt_rdata, 32'h0);
        check_eq("midrst_hi", bus_if.hi_rdata, 32'h0);
        check_eq("midrst_lo", bus_if.lo_rdata, 32'h0);
        bus_if.rs_addr = 5'd8;
        #1;
        check_eq("midrst_r8", bus_if.rs_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
